matrix_vec_mul: RTL and testbench

- Computes Y = A·X, where A is a 4x4 matrix and X is a 4-element column vector.
- All elements are unsigned N-bit values.
- Fully pipelined and free-running: every clock it accepts a new A/X and produces one result vector per cycle.
- Arithmetic leaf used by the matrix-math datapath; there is no handshake on the input side.

---
 rtl/matrix_vec_mul_pkg.sv | 18 +
 rtl/matrix_vec_mul_row_dot4.sv | 63 ++++++
 rtl/matrix_vec_mul.sv | 71 +++++++
 tb/tb_matrix_vec_mul.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/matrix_vec_mul_pkg.sv
// Shared constants and width helpers for the 4x4 matrix-vector multiplier.
package matrix_vec_mul_pkg;

    localparam int unsigned ELEM_W = 4;
    localparam int unsigned DIM    = 4;

    function automatic int unsigned row_width(input int unsigned n);
        return DIM * n;
    endfunction

    function automatic int unsigned res_width(input int unsigned n);
        return 2 * n;
    endfunction

    localparam int unsigned ROW_W = DIM * ELEM_W;
    localparam int unsigned RES_W = 2 * ELEM_W;

endpackage

// File: rtl/matrix_vec_mul_row_dot4.sv
// Two-stage unsigned 4-element dot product: registered products, then registered truncated sum.
module row_dot4
    import matrix_vec_mul_pkg::*;
#(
    parameter int unsigned N = ELEM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIM*N-1:0]        row,
    input  logic [N-1:0]            X1,
    input  logic [N-1:0]            X2,
    input  logic [N-1:0]            X3,
    input  logic [N-1:0]            X4,
    output logic [2*N-1:0]          y
);

    localparam int unsigned RW = res_width(N);
    localparam int unsigned SW = RW + 2;

    logic [N-1:0]  x_vec  [DIM];
    logic [RW-1:0] prod_d [DIM];
    logic [RW-1:0] prod_q [DIM];
    logic [SW-1:0] sum_full;
    logic [RW-1:0] y_d;
    logic [RW-1:0] y_q;

    // Stage 1: element j of the row sits MSB-first, so A_i1 is the top slice.
    always_comb begin
        x_vec[0] = X1;
        x_vec[1] = X2;
        x_vec[2] = X3;
        x_vec[3] = X4;
        for (int j = 0; j < int'(DIM); j++) begin
            prod_d[j] = RW'(row[(int'(DIM) - 1 - j) * int'(N) +: N]) * RW'(x_vec[j]);
        end
    end

    // Stage 2: carry headroom keeps the sum exact before the wrap to RW bits.
    always_comb begin
        sum_full = '0;
        for (int j = 0; j < int'(DIM); j++) begin
            sum_full = sum_full + SW'(prod_q[j]);
        end
        y_d = RW'(sum_full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(DIM); j++) begin
                prod_q[j] <= '0;
            end
            y_q <= '0;
        end else begin
            for (int j = 0; j < int'(DIM); j++) begin
                prod_q[j] <= prod_d[j];
            end
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/matrix_vec_mul.sv
// Free-running Y = A*X for a 4x4 unsigned matrix; one result per clock, two-edge latency.
module matrix_vec_mul
    import matrix_vec_mul_pkg::*;
#(
    parameter int unsigned N = ELEM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4*N-1:0]   A1,
    input  logic [4*N-1:0]   A2,
    input  logic [4*N-1:0]   A3,
    input  logic [4*N-1:0]   A4,
    input  logic [N-1:0]     X1,
    input  logic [N-1:0]     X2,
    input  logic [N-1:0]     X3,
    input  logic [N-1:0]     X4,
    output logic [2*N-1:0]   Y1,
    output logic [2*N-1:0]   Y2,
    output logic [2*N-1:0]   Y3,
    output logic [2*N-1:0]   Y4,
    output logic             y_valid
);

    localparam int unsigned RWID = row_width(N);
    localparam int unsigned YWID = res_width(N);

    logic [RWID-1:0] rows  [DIM];
    logic [YWID-1:0] y_row [DIM];
    logic [1:0]      valid_d;
    logic [1:0]      valid_q;

    assign rows[0] = A1;
    assign rows[1] = A2;
    assign rows[2] = A3;
    assign rows[3] = A4;

    for (genvar i = 0; i < int'(DIM); i++) begin : g_row
        row_dot4 #(
            .N (N)
        ) u_row (
            .clk (clk),
            .rst (rst),
            .row (rows[i]),
            .X1  (X1),
            .X2  (X2),
            .X3  (X3),
            .X4  (X4),
            .y   (y_row[i])
        );
    end

    // Valid tracks the datapath depth: a constant 1 walks through two flops.
    always_comb begin
        valid_d = {valid_q[0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign Y1      = y_row[0];
    assign Y2      = y_row[1];
    assign Y3      = y_row[2];
    assign Y4      = y_row[3];
    assign y_valid = valid_q[1];

endmodule

// File: tb/tb_matrix_vec_mul.sv
// Directed bench for matrix_vec_mul: per-edge history model plus literal spot checks.
module tb_matrix_vec_mul;

    localparam int N    = 4;
    localparam int MODV = 1 << (2 * N);
    localparam int HMAX = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*N-1:0] A1, A2, A3, A4;
    logic [N-1:0]   X1, X2, X3, X4;
    logic [2*N-1:0] Y1, Y2, Y3, Y4;
    logic           y_valid;

    int n_cmp = 0;
    int n_err = 0;
    int ecnt  = 0;
    bit done  = 1'b0;

    logic [N-1:0] a_tb [4][4];
    logic [N-1:0] x_tb [4];

    bit rst_h  [HMAX];
    int yexp_h [HMAX][4];

    always #5 clk = ~clk;

    matrix_vec_mul #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .A1      (A1),
        .A2      (A2),
        .A3      (A3),
        .A4      (A4),
        .X1      (X1),
        .X2      (X2),
        .X3      (X3),
        .X4      (X4),
        .Y1      (Y1),
        .Y2      (Y2),
        .Y3      (Y3),
        .Y4      (Y4),
        .y_valid (y_valid)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dot_row(input int i);
        int s = 0;
        for (int j = 0; j < 4; j++) s += int'(a_tb[i][j]) * int'(x_tb[j]);
        return s % MODV;
    endfunction

    task automatic apply();
        A1 = {a_tb[0][0], a_tb[0][1], a_tb[0][2], a_tb[0][3]};
        A2 = {a_tb[1][0], a_tb[1][1], a_tb[1][2], a_tb[1][3]};
        A3 = {a_tb[2][0], a_tb[2][1], a_tb[2][2], a_tb[2][3]};
        A4 = {a_tb[3][0], a_tb[3][1], a_tb[3][2], a_tb[3][3]};
        X1 = x_tb[0];
        X2 = x_tb[1];
        X3 = x_tb[2];
        X4 = x_tb[3];
    endtask

    task automatic set_rows_1234();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) a_tb[i][j] = N'(j + 1);
    endtask

    task automatic set_x(input int v0, input int v1, input int v2, input int v3);
        x_tb[0] = N'(v0); x_tb[1] = N'(v1); x_tb[2] = N'(v2); x_tb[3] = N'(v3);
    endtask

    task automatic tick();
        apply();
        @(negedge clk);
    endtask

    task automatic check_y(input string name, input int e1, input int e2,
                           input int e3, input int e4, input int ev);
        check({name, "_y1"}, int'(Y1), e1);
        check({name, "_y2"}, int'(Y2), e2);
        check({name, "_y3"}, int'(Y3), e3);
        check({name, "_y4"}, int'(Y4), e4);
        check({name, "_valid"}, int'(y_valid), ev);
    endtask

    // Record what each edge sampled: reset level and the ideal row results.
    always @(posedge clk) begin
        if (ecnt < HMAX - 1) begin
            ecnt = ecnt + 1;
            rst_h[ecnt] = rst;
            for (int i = 0; i < 4; i++) yexp_h[ecnt][i] = dot_row(i);
        end
    end

    // After edge e: zero if reset at e or e-1, otherwise the result sampled at e-1.
    always @(negedge clk) begin
        if (!done && ecnt >= 1) begin
            int exp_y [4];
            int exp_v;
            bit prev_rst;
            prev_rst = (ecnt >= 2) ? rst_h[ecnt - 1] : 1'b1;
            for (int i = 0; i < 4; i++)
                exp_y[i] = (rst_h[ecnt] || prev_rst) ? 0 : yexp_h[ecnt - 1][i];
            exp_v = (rst_h[ecnt] || prev_rst) ? 0 : 1;
            check("model_y1", int'(Y1), exp_y[0]);
            check("model_y2", int'(Y2), exp_y[1]);
            check("model_y3", int'(Y3), exp_y[2]);
            check("model_y4", int'(Y4), exp_y[3]);
            check("model_valid", int'(y_valid), exp_v);
        end
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) a_tb[i][j] = N'($urandom_range(15));
            x_tb[i] = N'($urandom_range(15));
        end
        apply();
        @(negedge clk);

        // Reset held for three edges with arbitrary inputs.
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) x_tb[j] = N'($urandom_range(15));
            tick();
            check_y("reset", 0, 0, 0, 0, 0);
        end

        // Basic: every row {1,2,3,4}, X all ones.
        rst = 1'b0;
        set_rows_1234();
        set_x(1, 1, 1, 1);
        tick();
        check("basic_valid_first_edge", int'(y_valid), 0);
        tick();
        check_y("basic", 10, 10, 10, 10, 1);

        // Diagonal rows pick out scaled vector elements.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) a_tb[i][j] = (i == j) ? N'(i + 1) : '0;
        set_x(5, 6, 7, 8);
        tick();
        tick();
        check_y("diag", 5, 12, 21, 32, 1);

        // All-ones-max: 900 wraps to 132.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) a_tb[i][j] = 4'hF;
        set_x(15, 15, 15, 15);
        tick();
        tick();
        check_y("wrap", 132, 132, 132, 132, 1);

        // Streaming X every cycle with no bubbles.
        set_rows_1234();
        set_x(1, 1, 1, 1);
        tick();
        set_x(2, 2, 2, 2);
        tick();
        check_y("stream0", 10, 10, 10, 10, 1);
        set_x(0, 0, 0, 0);
        tick();
        check_y("stream1", 20, 20, 20, 20, 1);
        tick();
        check_y("stream2", 0, 0, 0, 0, 1);

        // Single-cycle reset in the middle of a stream.
        set_x(1, 1, 1, 1);
        tick();
        set_x(2, 2, 2, 2);
        rst = 1'b1;
        tick();
        check_y("midrst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        set_x(3, 3, 3, 3);
        tick();
        check_y("midrst_edge1", 0, 0, 0, 0, 0);
        set_x(1, 1, 1, 1);
        tick();
        check_y("midrst_resume", 30, 30, 30, 30, 1);
        tick();
        check_y("midrst_next", 10, 10, 10, 10, 1);

        // Random traffic checked by the history model only.
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) a_tb[i][j] = N'($urandom_range(15));
                x_tb[i] = N'($urandom_range(15));
            end
            tick();
        end

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
